// File: rtl/vs_mux_demux_bank.sv
// vs_mux_demux_bank: four independent select paths (2:1 mux, 4:1 mux,
// 1:2 demux, 1:4 demux). Each has a purely combinational core followed by
// an output register. The block has no enables, no bypass and no other state.
//
// There is no handshake and no FSM. Outputs follow the sampled inputs with
// exactly one cycle of latency. Asserting rst_n low clears every output
// register at once, without waiting for a clock edge.

module vs_mux_demux_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel1,
  input  logic [1:0]       sel2,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] demux_in,
  output logic [WIDTH-1:0] mux2_out,
  output logic [WIDTH-1:0] mux4_out,
  output logic [WIDTH-1:0] dmx2_out0,
  output logic [WIDTH-1:0] dmx2_out1,
  output logic [WIDTH-1:0] dmx4_out0,
  output logic [WIDTH-1:0] dmx4_out1,
  output logic [WIDTH-1:0] dmx4_out2,
  output logic [WIDTH-1:0] dmx4_out3
);

  // Combinational results, one group per path
  logic [WIDTH-1:0] mux2_c;
  logic [WIDTH-1:0] mux4_c;
  logic [WIDTH-1:0] dmx2_c0;
  logic [WIDTH-1:0] dmx2_c1;
  logic [WIDTH-1:0] dmx4_c0;
  logic [WIDTH-1:0] dmx4_c1;
  logic [WIDTH-1:0] dmx4_c2;
  logic [WIDTH-1:0] dmx4_c3;

  // 2:1 mux: sel1 picks in0 or in1
  always_comb begin
    mux2_c = in0;
    if (sel1) mux2_c = in1;
  end

  // 4:1 mux: sel2 indexes in0..in3
  always_comb begin
    mux4_c = in0;
    case (sel2)
      2'd0: mux4_c = in0;
      2'd1: mux4_c = in1;
      2'd2: mux4_c = in2;
      2'd3: mux4_c = in3;
      default: mux4_c = in0;
    endcase
  end

  // 1:2 demux: route demux_in to the selected output and zero the other
  always_comb begin
    dmx2_c0 = '0;
    dmx2_c1 = '0;
    if (sel1) dmx2_c1 = demux_in;
    else      dmx2_c0 = demux_in;
  end

  // 1:4 demux: route demux_in to output sel2 and zero the other three
  always_comb begin
    dmx4_c0 = '0;
    dmx4_c1 = '0;
    dmx4_c2 = '0;
    dmx4_c3 = '0;
    case (sel2)
      2'd0: dmx4_c0 = demux_in;
      2'd1: dmx4_c1 = demux_in;
      2'd2: dmx4_c2 = demux_in;
      2'd3: dmx4_c3 = demux_in;
      default: dmx4_c0 = demux_in;
    endcase
  end

  // Mux output registers; async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux2_out <= '0;
      mux4_out <= '0;
    end else begin
      mux2_out <= mux2_c;
      mux4_out <= mux4_c;
    end
  end

  // 1:2 demux output registers; async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmx2_out0 <= '0;
      dmx2_out1 <= '0;
    end else begin
      dmx2_out0 <= dmx2_c0;
      dmx2_out1 <= dmx2_c1;
    end
  end

  // 1:4 demux output registers; async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmx4_out0 <= '0;
      dmx4_out1 <= '0;
      dmx4_out2 <= '0;
      dmx4_out3 <= '0;
    end else begin
      dmx4_out0 <= dmx4_c0;
      dmx4_out1 <= dmx4_c1;
      dmx4_out2 <= dmx4_c2;
      dmx4_out3 <= dmx4_c3;
    end
  end

endmodule

// File: tb/tb_vs_mux_demux_bank.sv
// Testbench for vs_mux_demux_bank. Inputs are driven on the falling edge
// and outputs are sampled on the following falling edge, which leaves the
// rising edge in between as the capture point. All eight outputs are
// compared as a single packed word:
//   {mux2, mux4, dmx2_0, dmx2_1, dmx4_0, dmx4_1, dmx4_2, dmx4_3}

module tb_vs_mux_demux_bank;

  localparam int W  = 4;
  localparam int PW = 8 * W;

  logic         clk;
  logic         rst_n;
  logic         sel1;
  logic [1:0]   sel2;
  logic [W-1:0] in0, in1, in2, in3, demux_in;
  logic [W-1:0] mux2_out, mux4_out, dmx2_out0, dmx2_out1;
  logic [W-1:0] dmx4_out0, dmx4_out1, dmx4_out2, dmx4_out3;

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] exp_q[$];
  string         name_q[$];

  vs_mux_demux_bank #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .sel1(sel1), .sel2(sel2),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .demux_in(demux_in),
    .mux2_out(mux2_out), .mux4_out(mux4_out),
    .dmx2_out0(dmx2_out0), .dmx2_out1(dmx2_out1),
    .dmx4_out0(dmx4_out0), .dmx4_out1(dmx4_out1),
    .dmx4_out2(dmx4_out2), .dmx4_out3(dmx4_out3)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         s1;
    logic [1:0]   s2;
    logic [W-1:0] i0, i1, i2, i3, d;
    logic [W-1:0] e_m2, e_m4, e_d20, e_d21, e_d40, e_d41, e_d42, e_d43;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [PW-1:0] actual();
    return {mux2_out, mux4_out, dmx2_out0, dmx2_out1,
            dmx4_out0, dmx4_out1, dmx4_out2, dmx4_out3};
  endfunction

  // Reference behaviour, used to build expectations for random stimulus
  function automatic logic [PW-1:0] model(input logic s1, input logic [1:0] s2,
      input logic [W-1:0] a, b, c, e, d);
    logic [W-1:0] m2, m4, y20, y21, y40, y41, y42, y43;
    logic [W-1:0] ins[4];
    logic [W-1:0] y4[4];
    ins[0] = a; ins[1] = b; ins[2] = c; ins[3] = e;
    m2 = s1 ? b : a;
    m4 = ins[s2];
    y20 = s1 ? '0 : d;
    y21 = s1 ? d : '0;
    for (int k = 0; k < 4; k++) y4[k] = (s2 == k[1:0]) ? d : '0;
    y40 = y4[0]; y41 = y4[1]; y42 = y4[2]; y43 = y4[3];
    return {m2, m4, y20, y21, y40, y41, y42, y43};
  endfunction

  // driver
  task automatic drive(input logic s1, input logic [1:0] s2,
      input logic [W-1:0] a, b, c, e, d);
    sel1 = s1; sel2 = s2; in0 = a; in1 = b; in2 = c; in3 = e; demux_in = d;
  endtask

  // scoreboard
  task automatic expect_out(input logic [PW-1:0] v, input string nm);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic check_out();
    logic [PW-1:0] e;
    string nm;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expected value queued, actual=%h", actual());
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    if (actual() !== e) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", nm, actual(), e);
    end
  endtask

  logic [PW-1:0] zeros;
  logic [PW-1:0] tmp;

  initial begin
    zeros = '0;
    // stimulus table
    //        s1    s2    i0    i1    i2    i3    d     m2    m4    d20   d21   d40   d41   d42   d43
    vecs[0] = '{1'b0, 2'd0, 4'h2, 4'h4, 4'h6, 4'h8, 4'h3, 4'h2, 4'h2, 4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0};
    vecs[1] = '{1'b1, 2'd1, 4'h2, 4'h4, 4'h6, 4'h8, 4'h3, 4'h4, 4'h4, 4'h0, 4'h3, 4'h0, 4'h3, 4'h0, 4'h0};
    vecs[2] = '{1'b0, 2'd2, 4'h2, 4'h4, 4'h6, 4'h8, 4'h3, 4'h2, 4'h6, 4'h3, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0};
    vecs[3] = '{1'b1, 2'd3, 4'h2, 4'h4, 4'h6, 4'h8, 4'h3, 4'h4, 4'h8, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h3};
    vecs[4] = '{1'b1, 2'd2, 4'hF, 4'h0, 4'hA, 4'h5, 4'hF, 4'h0, 4'hA, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    vecs[5] = '{1'b0, 2'd3, 4'hF, 4'h0, 4'hA, 4'h5, 4'h0, 4'hF, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[6] = '{1'b0, 2'd1, 4'h9, 4'hC, 4'h1, 4'h7, 4'hE, 4'h9, 4'hC, 4'hE, 4'h0, 4'h0, 4'hE, 4'h0, 4'h0};
    vecs[7] = '{1'b1, 2'd0, 4'h9, 4'hC, 4'h1, 4'h7, 4'h1, 4'hC, 4'h9, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};

    // reset block
    rst_n = 1'b0;
    drive(1'b1, 2'd3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    #2;
    expect_out(zeros, "reset_async_initial");
    check_out();
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_out(zeros, "reset_held_with_clock");
    check_out();
    rst_n = 1'b1;

    // table-driven vectors
    foreach (vecs[i]) begin
      drive(vecs[i].s1, vecs[i].s2, vecs[i].i0, vecs[i].i1, vecs[i].i2,
            vecs[i].i3, vecs[i].d);
      expect_out({vecs[i].e_m2, vecs[i].e_m4, vecs[i].e_d20, vecs[i].e_d21,
                  vecs[i].e_d40, vecs[i].e_d41, vecs[i].e_d42, vecs[i].e_d43},
                 $sformatf("table_vec%0d", i));
      @(negedge clk);
      check_out();
    end

    // latency: sel2 0->3 just after an edge
    drive(1'b0, 2'd0, 4'h2, 4'h4, 4'h6, 4'h8, 4'h3);
    @(posedge clk);
    #1;
    sel2 = 2'd3;
    @(negedge clk);
    expect_out({4'h2, 4'h2, 4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0}, "latency_hold");
    check_out();
    @(negedge clk);
    expect_out({4'h2, 4'h8, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3}, "latency_update");
    check_out();

    // mid-run reset between edges
    drive(1'b1, 2'd2, 4'h2, 4'h4, 4'h6, 4'h8, 4'h3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(zeros, "midrun_reset_immediate");
    check_out();
    @(posedge clk);
    #1;
    expect_out(zeros, "midrun_reset_held");
    check_out();
    @(negedge clk);
    drive(1'b0, 2'd1, 4'h5, 4'hA, 4'hC, 4'h3, 4'h7);
    rst_n = 1'b1;
    #1;
    expect_out(zeros, "reset_release_before_edge");
    check_out();
    @(negedge clk);
    expect_out({4'h5, 4'hA, 4'h7, 4'h0, 4'h0, 4'h7, 4'h0, 4'h0}, "reset_release_first_edge");
    check_out();

    // random stimulus against the model
    for (int n = 0; n < 24; n++) begin
      drive(1'($urandom_range(1)), 2'($urandom_range(3)),
            W'($urandom_range(15)), W'($urandom_range(15)),
            W'($urandom_range(15)), W'($urandom_range(15)),
            W'($urandom_range(15)));
      tmp = model(sel1, sel2, in0, in1, in2, in3, demux_in);
      expect_out(tmp, $sformatf("random%0d", n));
      @(negedge clk);
      check_out();
    end

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: actual=%0d queued expected=0", exp_q.size());
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
